// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter: fetch (m0) and data (m1) share one slave.
// Round-robin on contention, one transfer per grant, optional wait timeout.
module wb_dual_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_ack,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_e        state_q;
  logic          last_q;
  logic [CW-1:0] cnt_q;
  logic          err0_q;
  logic          err1_q;

  logic req0;
  logic req1;
  logic own0;
  logic own1;
  logic tmo;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;
  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign tmo  = TO_EN && (cnt_q == TMAX);

  // Arbitration, completion, abort and timeout sequencing.
  // last_q=1 means m1 was served last, so m0 wins the next tie.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req0 && (!req1 || last_q)) begin
            state_q <= OWN0;
          end else if (req1) begin
            state_q <= OWN1;
          end
        end
        OWN0: begin
          if (s_ack) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
          end else if (!m0_cyc) begin
            state_q <= IDLE;
          end else if (tmo) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            err0_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        OWN1: begin
          if (s_ack) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
          end else if (!m1_cyc) begin
            state_q <= IDLE;
          end else if (tmo) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            err1_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Forward the owner's bus to the slave; idle bus is all zero.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    unique case (1'b1)
      own0: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        m0_ack  = s_ack;
      end
      own1: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        m1_ack  = s_ack;
      end
      default: ;
    endcase
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_err   = err0_q;
  assign m1_err   = err1_q;
  assign grant    = {own1, own0};
  assign busy     = own0 | own1;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_wb_dual_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack, m0_err;
  logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata = '0;
  logic          s_ack = 1'b0;
  logic [1:0]    grant;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int ack1_cnt = 0;

  wb_dual_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (m1_ack === 1'b1) ack1_cnt++;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got=%b exp=00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_scyc got=%b exp=0", s_cyc); end
    checks++; if ({m0_err, m1_err, m0_ack, m1_ack} !== 4'b0) begin errors++; $display("FAIL rst_err_ack got=%b exp=0000", {m0_err, m1_err, m0_ack, m1_ack}); end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_rel_grant got=%b exp=00", grant); end
  endtask

  task automatic test_single();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h100;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b110) begin errors++; $display("FAIL single_sbus got=%b exp=110", {s_cyc, s_stb, s_we}); end
    checks++; if (s_addr !== 32'h100) begin errors++; $display("FAIL single_addr got=%h exp=00000100", s_addr); end
    step();
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL single_noack got=%b exp=0", m0_ack); end
    step();
    s_ack = 1; s_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL single_ack got=%b exp=1", m0_ack); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", m0_rdata); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL single_m1ack got=%b exp=0", m1_ack); end
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_idle got=%b exp=00", grant); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL single_idle_ack got=%b exp=0", m0_ack); end
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  task automatic test_contention();
    logic [1:0]    eg;
    logic [AW-1:0] ea;
    rst_n = 0;
    step();
    rst_n = 1;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h1000;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      ea = (i % 2 == 0) ? 32'h1000 : 32'h2000;
      step();
      checks++; if (grant !== eg) begin errors++; $display("FAIL cont_grant%0d got=%b exp=%b", i, grant, eg); end
      checks++; if (s_addr !== ea) begin errors++; $display("FAIL cont_addr%0d got=%h exp=%h", i, s_addr, ea); end
      s_ack = 1;
      #1;
      checks++; if ({m1_ack, m0_ack} !== eg) begin errors++; $display("FAIL cont_ack%0d got=%b exp=%b", i, {m1_ack, m0_ack}, eg); end
      step();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_gap%0d got=%b exp=00", i, grant); end
      s_ack = 0;
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step();
  endtask

  task automatic test_write();
    int a0;
    a0 = ack1_cnt;
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    m1_addr = 32'h8000_0004; m1_wdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant%0d got=%b exp=10", i, grant); end
      checks++; if ({s_stb, s_we} !== 2'b11) begin errors++; $display("FAIL wr_stbwe%0d got=%b exp=11", i, {s_stb, s_we}); end
      checks++; if (s_addr !== 32'h8000_0004) begin errors++; $display("FAIL wr_addr%0d got=%h exp=80000004", i, s_addr); end
      checks++; if (s_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_data%0d got=%h exp=12345678", i, s_wdata); end
    end
    s_ack = 1;
    #1;
    checks++; if ({m1_ack, m0_ack} !== 2'b10) begin errors++; $display("FAIL wr_ack got=%b exp=10", {m1_ack, m0_ack}); end
    step();
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL wr_idle_stb got=%b exp=0", s_stb); end
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    step();
    step();
    checks++; if (ack1_cnt - a0 !== 1) begin errors++; $display("FAIL wr_ackcount got=%0d exp=1", ack1_cnt - a0); end
  endtask

  task automatic test_timeout();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h40;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h50; m1_we = 0;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL to_grant got=%b exp=01", grant); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if ({grant, m0_err} !== 3'b010) begin errors++; $display("FAIL to_wait%0d got=%b exp=010", i, {grant, m0_err}); end
    end
    step();
    checks++; if (m0_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", m0_err); end
    checks++; if ({grant, s_cyc, m1_err, m0_ack} !== 5'b0) begin errors++; $display("FAIL to_idle got=%b exp=00000", {grant, s_cyc, m1_err, m0_ack}); end
    m0_cyc = 0; m0_stb = 0;
    step();
    checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got=%b exp=0", m0_err); end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_next got=%b exp=10", grant); end
    s_ack = 1;
    step();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();
  endtask

  task automatic test_boundary();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h60;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL bnd_grant got=%b exp=01", grant); end
    for (int i = 1; i <= 4; i++) step();
    s_ack = 1;
    #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL bnd_ack got=%b exp=1", m0_ack); end
    step();
    checks++; if ({grant, m0_err} !== 3'b000) begin errors++; $display("FAIL bnd_noerr got=%b exp=000", {grant, m0_err}); end
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step();
    checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL bnd_noerr2 got=%b exp=0", m0_err); end
  endtask

  task automatic test_abort_reset();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h70;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ab_grant got=%b exp=10", grant); end
    step();
    m1_cyc = 0; m1_stb = 0;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL ab_scyc got=%b exp=0", s_cyc); end
    step();
    checks++; if ({grant, m1_ack, m1_err} !== 4'b0) begin errors++; $display("FAIL ab_idle got=%b exp=0000", {grant, m1_ack, m1_err}); end
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ab_rr got=%b exp=10", grant); end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step();
    m0_cyc = 1; m0_stb = 1;
    step();
    checks++; if ({grant, s_cyc} !== 3'b011) begin errors++; $display("FAIL rs_own got=%b exp=011", {grant, s_cyc}); end
    #2;
    rst_n = 0; s_ack = 1;
    #1;
    checks++; if ({grant, s_cyc, m0_ack, m1_ack} !== 5'b0) begin errors++; $display("FAIL rs_async got=%b exp=00000", {grant, s_cyc, m0_ack, m1_ack}); end
    step();
    rst_n = 1; s_ack = 0;
    #1;
    checks++; if ({grant, m0_err, m1_err} !== 4'b0) begin errors++; $display("FAIL rs_release got=%b exp=0000", {grant, m0_err, m1_err}); end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rs_rearb got=%b exp=01", grant); end
    m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_write();
    test_timeout();
    test_boundary();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
